// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating mux: arbitration modes and
// a helper for the channel-index width.
package rr_arb_mux_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    function automatic int unsigned sel_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: fixed priority (lowest index wins) or round
// robin from a rotating pointer that moves past the last granted channel.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned MODE = MODE_RR
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NCH-1:0] req,
    input  logic           advance,
    output logic [NCH-1:0] grant
);

    localparam int unsigned SW = sel_width(NCH);

    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] start;
    logic [SW-1:0] idx;
    logic [SW-1:0] gnt_idx;

    assign start = (MODE == MODE_RR) ? ptr_q : '0;

    // Scan upward from start, wrapping at NCH-1; the first requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = SW'((32'(start) + i) % NCH);
            if (grant == '0 && req[idx]) begin
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                gnt_idx = SW'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (MODE == MODE_RR && advance && |grant) begin
            ptr_d = (gnt_idx == SW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrating mux with a single registered output stage; the arbiter
// decides the winner and this level only selects and registers its word.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4,
    parameter int unsigned MODE  = MODE_RR
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic [NCH-1:0]            in_valid,
    input  logic [NCH*WIDTH-1:0]      in_data,
    output logic [NCH-1:0]            in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [sel_width(NCH)-1:0] out_sel,
    input  logic                      out_ready
);

    localparam int unsigned SW = sel_width(NCH);

    logic [NCH-1:0]   grant;
    logic             load;
    logic [WIDTH-1:0] sel_data;
    logic [SW-1:0]    sel_idx;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SW-1:0]    out_sel_q;

    // Register can take a word when empty or draining this cycle; flush blocks it.
    assign load     = (~out_valid_q | out_ready) & ~flush;
    assign in_ready = grant & {NCH{load}};

    rr_arbiter #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (in_valid),
        .advance (load),
        .grant   (grant)
    );

    always_comb begin
        sel_data = '0;
        sel_idx  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_idx  = SW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            if (|grant) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_sel_q   <= sel_idx;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: round-robin and fixed-priority instances share stimulus
// and are checked every cycle against a queue-free behavioural model.
module tb_rr_arb_mux;

    logic         clk;
    logic         rstn;
    logic         flush;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic [3:0]   rr_ready, fx_ready;
    logic         rr_valid, fx_valid;
    logic [31:0]  rr_data, fx_data;
    logic [1:0]   rr_sel, fx_sel;

    int total = 0;
    int bad   = 0;

    rr_arb_mux #(.WIDTH(32), .NCH(4), .MODE(1)) u_rr (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rr_ready),
        .out_valid (rr_valid),
        .out_data  (rr_data),
        .out_sel   (rr_sel),
        .out_ready (out_ready)
    );

    rr_arb_mux #(.WIDTH(32), .NCH(4), .MODE(0)) u_fx (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (fx_ready),
        .out_valid (fx_valid),
        .out_data  (fx_data),
        .out_sel   (fx_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index 0 = fixed priority, index 1 = round robin.
    logic        m_valid [2];
    logic [31:0] m_data  [2];
    int          m_sel   [2];
    int          m_ptr   [2];

    function automatic int pick(input logic [3:0] v, input int start);
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (start + i) % 4;
            if (v[2'(c)]) return c;
        end
        return -1;
    endfunction

    function automatic logic m_load(input int m);
        return (!m_valid[m] || out_ready) && !flush;
    endfunction

    function automatic logic [3:0] m_ready(input int m);
        int g;
        logic [3:0] r;
        g = pick(in_valid, m_ptr[m]);
        r = 4'b0000;
        if (m_load(m) && g >= 0) r[2'(g)] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int m = 0; m < 2; m++) begin
                m_valid[m] <= 1'b0;
                m_data[m]  <= '0;
                m_sel[m]   <= 0;
                m_ptr[m]   <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                int g;
                g = pick(in_valid, m_ptr[m]);
                if (m_load(m)) begin
                    if (g >= 0) begin
                        m_valid[m] <= 1'b1;
                        m_data[m]  <= in_data[g*32 +: 32];
                        m_sel[m]   <= g;
                        if (m == 1) m_ptr[m] <= (g + 1) % 4;
                    end else begin
                        m_valid[m] <= 1'b0;
                    end
                end else if (flush) begin
                    m_valid[m] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("rr_valid", {31'b0, rr_valid}, {31'b0, m_valid[1]});
            chk("rr_data", rr_data, m_data[1]);
            chk("rr_sel", {30'b0, rr_sel}, 32'(m_sel[1]));
            chk("rr_ready", {28'b0, rr_ready}, {28'b0, m_ready(1)});
            chk("fx_valid", {31'b0, fx_valid}, {31'b0, m_valid[0]});
            chk("fx_data", fx_data, m_data[0]);
            chk("fx_sel", {30'b0, fx_sel}, 32'(m_sel[0]));
            chk("fx_ready", {28'b0, fx_ready}, {28'b0, m_ready(0)});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base + 32'(i);
    endtask

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 4'b0000;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) next_cycle();
        chk("rst_valid", {31'b0, rr_valid}, 32'd0);
        chk("rst_data", rr_data, 32'd0);
        chk("rst_sel", {30'b0, rr_sel}, 32'd0);
        rstn = 1'b1;

        // Round robin rotation, fixed priority always channel 0.
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        set_data(32'h1000);
        #1 chk("rr_first_ready", {28'b0, rr_ready}, 32'b0001);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            chk("rr_seq_valid", {31'b0, rr_valid}, 32'd1);
            chk("rr_seq_sel", {30'b0, rr_sel}, 32'(k % 4));
            chk("rr_seq_data", rr_data, 32'h1000 + 32'(k % 4));
            chk("fx_seq_sel", {30'b0, fx_sel}, 32'd0);
            chk("fx_seq_data", fx_data, 32'h1000);
        end

        // Backpressure holds the registered word.
        in_data = {4{32'hDEADBEEF}};
        next_cycle();
        chk("bp_load_sel", {30'b0, rr_sel}, 32'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", {28'b0, rr_ready}, 32'b0000);
            next_cycle();
            chk("bp_data", rr_data, 32'hDEADBEEF);
            chk("bp_valid", {31'b0, rr_valid}, 32'd1);
        end
        set_data(32'h55);
        out_ready = 1'b1;
        #1 chk("bp_resume_ready", {28'b0, rr_ready}, 32'b0100);
        next_cycle();
        chk("bp_resume_sel", {30'b0, rr_sel}, 32'd2);
        chk("bp_resume_data", rr_data, 32'h57);

        // Wrap: pointer at 3, only channel 1 requesting.
        in_valid = 4'b0010;
        #1 chk("wrap_ready", {28'b0, rr_ready}, 32'b0010);
        next_cycle();
        chk("wrap_sel", {30'b0, rr_sel}, 32'd1);
        in_valid = 4'b1111;
        #1 chk("wrap_ptr", {28'b0, rr_ready}, 32'b0100);
        next_cycle();

        // Flush wins over ready and valid, pointer holds at 3.
        flush = 1'b1;
        #1 chk("flush_ready", {28'b0, rr_ready}, 32'b0000);
        next_cycle();
        chk("flush_valid", {31'b0, rr_valid}, 32'd0);
        flush = 1'b0;
        #1 chk("flush_ptr", {28'b0, rr_ready}, 32'b1000);
        next_cycle();
        chk("post_flush_sel", {30'b0, rr_sel}, 32'd3);

        // Asynchronous reset mid-cycle while holding a word.
        #1 rstn = 1'b0;
        #1;
        chk("async_valid", {31'b0, rr_valid}, 32'd0);
        chk("async_data", rr_data, 32'd0);
        chk("async_sel", {30'b0, rr_sel}, 32'd0);
        next_cycle();
        rstn = 1'b1;
        #1 chk("post_rst_ready", {28'b0, rr_ready}, 32'b0001);
        next_cycle();
        chk("post_rst_sel", {30'b0, rr_sel}, 32'd0);

        // Random traffic checked by the compare process.
        for (int k = 0; k < 3000; k++) begin
            in_valid  = 4'($urandom);
            for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(9) == 0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
